// File: rtl/led_axi_slave.sv
// AXI4-Lite slave with four word registers driving a blinking LED bank; LED is registered one cycle after its inputs.
// Ready pulses one cycle after valid(s) are seen; no new write/read is accepted while BVALID/RVALID wait for BREADY/RREADY.
module led_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_WIDTH          = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_WIDTH-1:0]            LED
);

  localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] IDX_DIVIDER = 2'd1;

  logic                          wr_rdy_q, wr_rdy_d;
  logic                          bvalid_q, bvalid_d;
  logic                          ar_rdy_q, ar_rdy_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [4];
  logic [31:0]                   cnt_q, cnt_d;
  logic                          phase_q, phase_d;
  logic [LED_WIDTH-1:0]          led_q, led_d;

  logic       wr_en, rd_en;
  logic [1:0] wr_idx, rd_idx;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_idx = S_AXI_AWADDR[3:2];
    rd_idx = S_AXI_ARADDR[3:2];
    wr_en  = wr_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_en  = ar_rdy_q & S_AXI_ARVALID;

    wr_rdy_d = ~wr_rdy_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    bvalid_d = wr_en | (bvalid_q & ~S_AXI_BREADY);

    regs_d = regs_q;
    if (wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (S_AXI_WSTRB[b]) regs_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
    end

    // Read data is taken from the pre-edge registers, so a same-cycle write is not visible.
    ar_rdy_d = ~ar_rdy_q & S_AXI_ARVALID & ~rvalid_q;
    rvalid_d = rd_en | (rvalid_q & ~S_AXI_RREADY);
    rdata_d  = rd_en ? regs_q[rd_idx] : rdata_q;

    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if ((wr_en && wr_idx == IDX_DIVIDER) || regs_q[IDX_DIVIDER] == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == regs_q[IDX_DIVIDER]) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end

    led_d = regs_q[0][LED_WIDTH-1:0] ^ (regs_q[2][LED_WIDTH-1:0] & {LED_WIDTH{phase_q}});
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      led_q    <= '0;
    end else begin
      wr_rdy_q <= wr_rdy_d;
      bvalid_q <= bvalid_d;
      ar_rdy_q <= ar_rdy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign S_AXI_AWREADY = wr_rdy_q;
  assign S_AXI_WREADY  = wr_rdy_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign LED           = led_q;

endmodule

// File: tb/tb_led_axi_slave.sv
// Directed bench for led_axi_slave: read data is checked against a queue of expected words
// filled when each read is issued; LED blinking is checked against a small counter/phase model.
module tb_led_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [7:0]  LED;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr_acc = 0;
  logic [31:0] exp_q[$];

  led_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .LED_WIDTH(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .LED(LED)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID) n_wr_acc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr_hs();
    int t = 0;
    do begin @(posedge ACLK); #1; t++; end
    while (!(S_AXI_AWREADY && S_AXI_WREADY) && t < 50);
    check("wr_handshake", 32'(S_AXI_AWREADY & S_AXI_WREADY), 32'd1);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    wait_wr_hs();
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check($sformatf("bvalid@%h", a), 32'(S_AXI_BVALID), 32'd1);
    check($sformatf("bresp@%h", a), 32'(S_AXI_BRESP), 32'd0);
    check($sformatf("awready_pulse@%h", a), 32'(S_AXI_AWREADY), 32'd0);
    @(posedge ACLK); #1;
    check($sformatf("bvalid_clear@%h", a), 32'(S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    int t = 0;
    logic [31:0] e;
    exp_q.push_back(exp);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    do begin @(posedge ACLK); #1; t++; end
    while (!S_AXI_ARREADY && t < 50);
    check("ar_handshake", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    t = 0;
    while (!S_AXI_RVALID && t < 50) begin @(posedge ACLK); #1; t++; end
    check($sformatf("rvalid@%h", a), 32'(S_AXI_RVALID), 32'd1);
    e = exp_q.pop_front();
    check($sformatf("rdata@%h", a), S_AXI_RDATA, e);
    check($sformatf("rresp@%h", a), 32'(S_AXI_RRESP), 32'd0);
    @(posedge ACLK); #1;
  endtask

  initial begin
    logic [31:0] m_cnt;
    logic        m_ph;
    logic [7:0]  m_led;
    logic [31:0] e;
    int          acc0;
    int          t;

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'b010; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b001; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset state
    #22;
    check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    #5 ARESETN = 1'b1;

    // Basic write/readback of all four registers, then unaligned reads
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'hC, 32'h4, 4'hF);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_read(4'hC, 32'h4);
    axi_read(4'h6, 32'h2);
    axi_read(4'hB, 32'h3);

    // Byte strobes, with the full write issued at an unaligned address
    axi_write(4'hF, 32'h11223344, 4'hF);
    axi_write(4'hC, 32'hAABBCCDD, 4'b0101);
    axi_read(4'hD, 32'h11BB33DD);

    // Write response held off: no second accept until BREADY handshake
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h66; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    wait_wr_hs();
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h55;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bvalid_hold%0d", i), 32'(S_AXI_BVALID), 32'd1);
      check($sformatf("awready_blocked%0d", i), 32'(S_AXI_AWREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    wait_wr_hs();
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("bvalid_second", 32'(S_AXI_BVALID), 32'd1);
    @(posedge ACLK); #1;
    axi_read(4'h8, 32'h66);
    axi_read(4'hC, 32'h55);

    // Same-cycle read and write of SCRATCH: read sees the old value
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'hC;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    exp_q.push_back(32'h55);
    t = 0;
    do begin @(posedge ACLK); #1; t++; end
    while (!S_AXI_ARREADY && t < 50);
    check("coll_arready", 32'(S_AXI_ARREADY), 32'd1);
    check("coll_awready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    check("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("coll_bvalid", 32'(S_AXI_BVALID), 32'd1);
    e = exp_q.pop_front();
    check("coll_rdata_old", S_AXI_RDATA, e);
    @(posedge ACLK); #1;
    axi_read(4'hC, 32'h99);

    // AWVALID alone is not accepted until WVALID arrives; exactly one write
    acc0 = n_wr_acc;
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      check($sformatf("aw_only_awready%0d", i), 32'(S_AXI_AWREADY), 32'd0);
      check($sformatf("aw_only_wready%0d", i), 32'(S_AXI_WREADY), 32'd0);
    end
    S_AXI_WVALID = 1'b1;
    wait_wr_hs();
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("aw_only_bvalid", 32'(S_AXI_BVALID), 32'd1);
    @(posedge ACLK); #1;
    check("aw_only_single_accept", 32'(n_wr_acc - acc0), 32'd1);
    axi_read(4'h8, 32'h77);

    // Blinking: PATTERN=0x0F, BLINK_MASK=0xFF, DIVIDER=3
    axi_write(4'h0, 32'h0F, 4'hF);
    axi_write(4'h8, 32'hFF, 4'hF);
    axi_write(4'h4, 32'h3, 4'hF);
    // Model state right after the DIVIDER accept edge; one edge has passed since.
    m_cnt = 0; m_ph = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin @(posedge ACLK); #1; end
      m_led = 8'h0F ^ ({8{m_ph}} & 8'hFF);
      if (m_cnt == 32'd3) begin m_cnt = 0; m_ph = ~m_ph; end
      else m_cnt = m_cnt + 1;
      check($sformatf("blink_led%0d", i), 32'(LED), 32'(m_led));
    end
    axi_write(4'h4, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("steady_led%0d", i), 32'(LED), 32'h0F);
      @(posedge ACLK); #1;
    end

    // Reset while a read response is pending
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    t = 0;
    do begin @(posedge ACLK); #1; t++; end
    while (!S_AXI_ARREADY && t < 50);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    check("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'd1);
    check("pre_rst_rdata", S_AXI_RDATA, 32'h0F);
    #2 ARESETN = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    check("mid_rst_rdata", S_AXI_RDATA, 32'd0);
    check("mid_rst_led", 32'(LED), 32'd0);
    check("mid_rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    @(posedge ACLK); #3;
    ARESETN = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    axi_read(4'h0, 32'h0);
    axi_read(4'h4, 32'h0);
    axi_read(4'h8, 32'h0);
    axi_read(4'hC, 32'h0);
    check("post_rst_led", 32'(LED), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_axi_slave.md
LED_AXI_SLAVE -- requirements
Module: led_axi_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width (4 word registers).
REQ-003 SHALL have parameter LED_WIDTH, default 8, number of LED outputs (1..32).
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-006 S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address; S_AXI_AWPROT  in  3  ignored.
REQ-007 S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write address handshake.
REQ-008 S_AXI_WDATA  in  32  write data; S_AXI_WSTRB  in  4  byte enables.
REQ-009 S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write data handshake.
REQ-010 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response.
REQ-011 S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT in 3 ignored; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-012 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read channel.
REQ-013 LED  out  LED_WIDTH  LED drive, registered.

Function
REQ-014 Registers, word index = ADDR[3:2]: 0 PATTERN, 1 DIVIDER, 2 BLINK_MASK, 3 SCRATCH; all 32-bit, fully read/write, readback equals last written value.
REQ-015 Write accept: when AWVALID and WVALID both high, no write accepted in previous cycle, and BVALID low, AWREADY and WREADY SHALL pulse high together for exactly one cycle.
REQ-016 Register update on the accept edge; byte n written only if WSTRB[n]=1; other bytes retained.
REQ-017 BVALID SHALL rise the cycle after accept, BRESP=2'b00, held until BREADY sampled high; no new write accepted while BVALID high.
REQ-018 AWVALID without WVALID (or reverse) SHALL NOT be accepted; master holds until both present.
REQ-019 Read accept: ARREADY SHALL pulse one cycle when ARVALID high and RVALID low; address latched on accept.
REQ-020 RVALID SHALL rise cycle after accept with RDATA=addressed register, RRESP=2'b00; RDATA/RVALID stable until RREADY high.
REQ-021 Read and write to same register accepted same cycle: read returns pre-write value.
REQ-022 Blink counter: 32-bit, increments each cycle; when counter == DIVIDER it clears to 0 and toggles blink_phase; DIVIDER==0 SHALL hold counter at 0 and blink_phase at 0.
REQ-023 Write to DIVIDER SHALL clear counter and blink_phase on the same edge.
REQ-024 LED SHALL equal PATTERN[LED_WIDTH-1:0] XOR (BLINK_MASK[LED_WIDTH-1:0] AND replicated blink_phase), registered one cycle after inputs.
REQ-025 Address bits [1:0] ignored; unaligned accesses map to containing word.

Reset
REQ-026 ARESETN low SHALL asynchronously clear all registers, counter, blink_phase, LED, AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, BRESP, RRESP to 0.
REQ-027 Reset mid-transaction SHALL abandon it; after deassertion no pending BVALID/RVALID; first accept possible on second rising edge after deassertion.

Verification
REQ-028 After reset, write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> reads 0x1,0x2,0x3,0x4, all RESP=OKAY.
REQ-029 Write 0xAABBCCDD to 0xC with WSTRB=4'b0101 over 0x11223344 -> read 0xC returns 0x11BB33DD.
REQ-030 BREADY held low 5 cycles after write -> BVALID stays high 5 cycles, second AW/W pair not accepted until BREADY handshake completes.
REQ-031 PATTERN=0x0F, BLINK_MASK=0xFF, DIVIDER=3 -> LED alternates 0x0F/0xF0 every 4 cycles; DIVIDER=0 -> LED steady 0x0F.
REQ-032 AWVALID alone for 3 cycles, then WVALID -> AWREADY/WREADY pulse only after WVALID, single write.
REQ-033 ARESETN low while RVALID pending -> RVALID, LED, all registers 0 immediately; read after release returns 0.
